// File: rtl/regfile_dump_if.sv
// ============================================================================
// Module      : regfile_dump_if
// Description : Valid/ready beat stream from the register dump engine to a
//               debug sink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_dump_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/regfile_dump.sv
// ============================================================================
// Module      : regfile_dump
// Description : Walks register indices FIRST_REG..LAST_REG on a spare
//               register-file read port and streams one beat per register.
//               Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum beat.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_dump #(
  parameter int unsigned FIRST_REG = 1,
  parameter int unsigned LAST_REG  = 31
) (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        start,
  input  wire logic        abort,
  output logic      [4:0]  rf_read_register,
  input  wire logic [31:0] rf_read_data,
  regfile_dump_if.master   stream,
  output logic             busy,
  output logic             done
);

  localparam logic [4:0] c_FIRST_REG = 5'(FIRST_REG);
  localparam logic [4:0] c_LAST_REG  = 5'(LAST_REG);

  typedef enum logic [2:0] {
    c_IDLE = 3'd0,
    c_READ = 3'd1,
    c_SEND = 3'd2,
`ifdef REGFILE_DUMP_CHECKSUM_EN
    c_CSUM = 3'd3,
`endif
    c_DONE = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [4:0]  r_ptr;
  logic [4:0]  w_next_ptr;
  logic [4:0]  w_next_rf_addr;
  logic [31:0] r_out_data;
  logic [4:0]  r_out_index;
  logic        r_out_last;
  logic        w_out_valid;
  logic        w_ptr_is_last;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [31:0] r_csum;
  assign w_out_valid = (r_state == c_SEND) || (r_state == c_CSUM);
`else
  assign w_out_valid = (r_state == c_SEND);
`endif

  assign w_ptr_is_last = (r_ptr == c_LAST_REG);

  always_comb begin
    w_next_state = r_state;
    w_next_ptr   = r_ptr;
    case (r_state)
      c_IDLE: begin
        if (start && !abort) begin
          w_next_state = c_READ;
          w_next_ptr   = c_FIRST_REG;
        end
      end
      c_READ: w_next_state = c_SEND;
      c_SEND: begin
        if (stream.out_ready) begin
          if (w_ptr_is_last) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            w_next_state = c_CSUM;
`else
            w_next_state = c_DONE;
`endif
          end else begin
            w_next_ptr   = r_ptr + 5'd1;
            w_next_state = c_READ;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      c_CSUM: begin
        if (stream.out_ready) begin
          w_next_state = c_DONE;
        end
      end
`endif
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
    // Abort beats any handshake completing in the same cycle.
    if (abort && (r_state != c_IDLE)) begin
      w_next_state = c_IDLE;
    end
    w_next_rf_addr = (w_next_state == c_READ) ? w_next_ptr : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state          <= c_IDLE;
      r_ptr            <= 5'd0;
      rf_read_register <= 5'd0;
      r_out_data       <= 32'd0;
      r_out_index      <= 5'd0;
      r_out_last       <= 1'b0;
    end else begin
      r_state          <= w_next_state;
      r_ptr            <= w_next_ptr;
      rf_read_register <= w_next_rf_addr;
      if (r_state == c_READ) begin
        r_out_data  <= rf_read_data;
        r_out_index <= r_ptr;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        r_out_last  <= 1'b0;
`else
        r_out_last  <= w_ptr_is_last;
`endif
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      if ((r_state == c_SEND) && (w_next_state == c_CSUM)) begin
        r_out_data  <= r_csum;
        r_out_index <= 5'd0;
        r_out_last  <= 1'b1;
      end
`endif
    end
  end

`ifdef REGFILE_DUMP_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_csum <= 32'd0;
    end else if ((r_state == c_IDLE) && start && !abort) begin
      r_csum <= 32'd0;
    end else if (r_state == c_READ) begin
      r_csum <= r_csum ^ rf_read_data;
    end
  end
`endif

  assign stream.out_valid = w_out_valid;
  assign stream.out_data  = r_out_data;
  assign stream.out_index = r_out_index;
  assign stream.out_last  = r_out_last;
  assign busy             = (r_state != c_IDLE);
  assign done             = (r_state == c_DONE);

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump.sv
// ============================================================================
// Module      : tb_regfile_dump
// Description : Directed self-checking bench for regfile_dump (default range
//               and a single-register 5..5 instance sharing clock and reset).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_dump;

`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, abort_a, start_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] regs [32];
  int          n_checks = 0;
  int          n_errors = 0;

  regfile_dump_if ifa ();
  regfile_dump_if ifb ();

  always #5 clk = ~clk;

  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];

  regfile_dump dut_a (
    .clk              (clk),
    .reset            (reset),
    .start            (start_a),
    .abort            (abort_a),
    .rf_read_register (rf_addr_a),
    .rf_read_data     (rf_data_a),
    .stream           (ifa.master),
    .busy             (busy_a),
    .done             (done_a)
  );

  regfile_dump #(.FIRST_REG(5), .LAST_REG(5)) dut_b (
    .clk              (clk),
    .reset            (reset),
    .start            (start_b),
    .abort            (1'b0),
    .rf_read_register (rf_addr_b),
    .rf_read_data     (rf_data_b),
    .stream           (ifb.master),
    .busy             (busy_b),
    .done             (done_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full dump of dut_a with register i = i*mult and the sink always ready.
  task automatic run_full(input logic [31:0] mult);
    int          cyc, exp_idx, done_cyc, first_cyc;
    logic [31:0] x;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i) * mult;
    x = 32'd0;
    for (int i = 1; i <= 31; i++) x = x ^ regs[i];
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("start_busy", busy_a, 1);
    check("start_rfaddr", rf_addr_a, 1);
    check("start_novalid", ifa.out_valid, 0);
    cyc = 0; exp_idx = 1; done_cyc = -1; first_cyc = -1;
    while (cyc < 200 && done_cyc < 0) begin
      if (ifa.out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (exp_idx <= 31) begin
          check("beat_index", ifa.out_index, exp_idx);
          check("beat_data", ifa.out_data, regs[exp_idx]);
          check("beat_last", ifa.out_last, (exp_idx == 31 && CS == 0) ? 1 : 0);
        end else begin
          check("csum_index", ifa.out_index, 0);
          check("csum_data", ifa.out_data, x);
          check("csum_last", ifa.out_last, 1);
        end
        exp_idx++;
      end else if (busy_a && !done_a) begin
        check("read_rfaddr", rf_addr_a, exp_idx);
      end
      if (done_a) done_cyc = cyc;
      tick();
      cyc++;
    end
    check("first_valid_cycle", first_cyc, 1);
    check("beat_count", exp_idx - 1, 31 + CS);
    check("done_cycle", done_cyc, 62 + CS);
    check("idle_after_done", busy_a, 0);
    check("done_one_cycle", done_a, 0);
  endtask

  initial begin
    int cyc, stall, xfers;
    logic done_seen;

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    reset = 1'b0; start_a = 1'b1; abort_a = 1'b0; start_b = 1'b1;
    ifa.out_ready = 1'b0; ifb.out_ready = 1'b0;

    // Reset held with start asserted
    repeat (3) tick();
    check("rst_busy", busy_a, 0);
    check("rst_valid", ifa.out_valid, 0);
    check("rst_rfaddr", rf_addr_a, 0);
    check("rst_data", ifa.out_data, 0);
    check("rst_index", ifa.out_index, 0);
    check("rst_last", ifa.out_last, 0);
    check("rst_done", done_a, 0);
    check("rst_busy_b", busy_b, 0);
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tick(); tick();
    check("post_rst_idle", busy_a, 0);
    check("post_rst_valid", ifa.out_valid, 0);

    // start with abort in IDLE stays idle
    start_a = 1'b1; abort_a = 1'b1;
    tick();
    start_a = 1'b0; abort_a = 1'b0;
    check("start_abort_idle", busy_a, 0);
    check("start_abort_rf", rf_addr_a, 0);

    run_full(32'h1111_1111);

    // Backpressure on the index-3 beat
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 0; stall = 0; xfers = 0; done_seen = 1'b0;
    while (cyc < 300 && !done_seen) begin
      ifa.out_ready = 1'b1;
      if (ifa.out_valid && ifa.out_index == 5'd3 && stall < 5) begin
        ifa.out_ready = 1'b0;
        stall++;
        check("stall_data", ifa.out_data, 32'h3333_3333);
        check("stall_last", ifa.out_last, 0);
      end
      if (ifa.out_valid && ifa.out_ready) begin
        if (xfers < 31) check("bp_index", ifa.out_index, xfers + 1);
        xfers++;
      end
      if (done_a) done_seen = 1'b1;
      tick();
      cyc++;
    end
    check("stall_cycles", stall, 5);
    check("bp_transfers", xfers, 31 + CS);
    check("bp_done_seen", done_seen, 1);

    // Abort during the index-10 beat, with ready also high
    ifa.out_ready = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    cyc = 0;
    while (!(ifa.out_valid && ifa.out_index == 5'd10) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("abort_reach_idx", ifa.out_index, 10);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("abort_busy", busy_a, 0);
    check("abort_valid", ifa.out_valid, 0);
    check("abort_rfaddr", rf_addr_a, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done_a) done_seen = 1'b1;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("restart_rfaddr", rf_addr_a, 1);
    tick();
    check("restart_valid", ifa.out_valid, 1);
    check("restart_index", ifa.out_index, 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("restart_abort_idle", busy_a, 0);

    // Single-register range; a start while busy is ignored
    ifb.out_ready = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_rfaddr", rf_addr_b, 5);
    check("b_busy", busy_b, 1);
    tick();
    check("b_valid", ifb.out_valid, 1);
    check("b_index", ifb.out_index, 5);
    check("b_data", ifb.out_data, regs[5]);
    check("b_last", ifb.out_last, (CS == 0) ? 1 : 0);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("b_hold_valid", ifb.out_valid, 1);
    check("b_hold_index", ifb.out_index, 5);
    ifb.out_ready = 1'b1;
    tick();
`ifdef REGFILE_DUMP_CHECKSUM_EN
    check("b_csum_index", ifb.out_index, 0);
    check("b_csum_data", ifb.out_data, regs[5]);
    check("b_csum_last", ifb.out_last, 1);
    tick();
`endif
    check("b_done", done_b, 1);
    check("b_valid_in_done", ifb.out_valid, 0);
    tick();
    check("b_idle", busy_b, 0);
    check("b_done_clear", done_b, 0);
    tick();
    check("b_no_requeue", busy_b, 0);

    // Registers i = i; XOR of 1..31 is zero
    run_full(32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
